// File: rtl/reset_receiver.sv
// reset_receiver: brings an asynchronous reset request into the local clock
// domain. It requires a minimum quiet time with the request low, then
// releases a bank of staged resets one at a time, lowest bit first.
module reset_receiver #(
  parameter int NUMBER_OF_STAGES    = 4,
  parameter int SYNCHRONIZER_DEPTH  = 2,
  parameter int MINIMUM_QUIET_LOG2  = 3,
  parameter int STAGE_DELAY_LOG2    = 4,
  parameter int EVENT_COUNTER_WIDTH = 8
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           upstream_reset_request,
  output logic [NUMBER_OF_STAGES-1:0]    stage_reset,
  output logic                           release_in_progress,
  output logic                           all_released,
  output logic [EVENT_COUNTER_WIDTH-1:0] reset_event_count
);

  // Counter widths are never zero, so degenerate parameter choices still elaborate.
  localparam int QW = (MINIMUM_QUIET_LOG2 > 0) ? MINIMUM_QUIET_LOG2 : 1;
  localparam int DW = (STAGE_DELAY_LOG2 > 0) ? STAGE_DELAY_LOG2 : 1;
  localparam int IW = (NUMBER_OF_STAGES > 1) ? $clog2(NUMBER_OF_STAGES) : 1;
  localparam int EW = EVENT_COUNTER_WIDTH;

  localparam logic [QW-1:0] QUIET_LAST = QW'((1 << MINIMUM_QUIET_LOG2) - 1);
  localparam logic [DW-1:0] DELAY_LAST = DW'((1 << STAGE_DELAY_LOG2) - 1);
  localparam logic [IW-1:0] LAST_INDEX = IW'(NUMBER_OF_STAGES - 1);

  typedef enum logic [1:0] {
    HOLD      = 2'd0,
    RELEASING = 2'd1,
    RUNNING   = 2'd2
  } state_t;

  // Power-up values match the values that reset loads.
  logic [SYNCHRONIZER_DEPTH-1:0] sync_chain_reg = '1;
  logic                          prev_sync_reg  = 1'b1;
  state_t                        state_reg      = HOLD;
  logic [QW-1:0]                 quiet_count_reg = '0;
  logic [DW-1:0]                 delay_count_reg = '0;
  logic [IW-1:0]                 stage_index_reg = '0;
  logic [NUMBER_OF_STAGES-1:0]   stage_reset_reg = '1;
  logic                          in_progress_reg = 1'b0;
  logic                          all_released_reg = 1'b0;
  logic [EW-1:0]                 event_count_reg = '0;

  state_t                        state_next;
  logic [QW-1:0]                 quiet_count_next;
  logic [DW-1:0]                 delay_count_next;
  logic [IW-1:0]                 stage_index_next;
  logic [NUMBER_OF_STAGES-1:0]   stage_reset_next;
  logic                          in_progress_next;
  logic                          all_released_next;
  logic [EW-1:0]                 event_count_next;

  logic                          sync_req;
  logic [NUMBER_OF_STAGES-1:0]   release_mask;

  assign sync_req = sync_chain_reg[SYNCHRONIZER_DEPTH-1];

  // One-hot select of the stage that the next delay expiry will release.
  generate
    for (genvar gi = 0; gi < NUMBER_OF_STAGES; gi++) begin : g_release_mask
      assign release_mask[gi] = (stage_index_reg == IW'(gi));
    end
  endgenerate

  // Request synchronizer; reset fills it with 1s so leaving reset never looks like a new request.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_chain_reg <= '1;
    end else begin
      sync_chain_reg <= {sync_chain_reg[SYNCHRONIZER_DEPTH-2:0], upstream_reset_request};
    end
  end

  // Next-state and registered-output logic for the release sequencer.
  always_comb begin
    state_next        = state_reg;
    quiet_count_next  = quiet_count_reg;
    delay_count_next  = delay_count_reg;
    stage_index_next  = stage_index_reg;
    stage_reset_next  = stage_reset_reg;
    in_progress_next  = in_progress_reg;
    all_released_next = all_released_reg;
    event_count_next  = event_count_reg;

    // Count rising edges of the synchronized request, holding at all-ones.
    if (sync_req && !prev_sync_reg && (event_count_reg != {EW{1'b1}})) begin
      event_count_next = event_count_reg + EW'(1);
    end

    if (sync_req) begin
      // A live request pulls every stage back into reset from any state.
      state_next        = HOLD;
      quiet_count_next  = '0;
      delay_count_next  = '0;
      stage_index_next  = '0;
      stage_reset_next  = '1;
      in_progress_next  = 1'b0;
      all_released_next = 1'b0;
    end else begin
      case (state_reg)
        HOLD: begin
          if (quiet_count_reg == QUIET_LAST) begin
            quiet_count_next    = '0;
            delay_count_next    = '0;
            stage_reset_next[0] = 1'b0;
            if (NUMBER_OF_STAGES == 1) begin
              state_next        = RUNNING;
              all_released_next = 1'b1;
            end else begin
              state_next       = RELEASING;
              in_progress_next = 1'b1;
              stage_index_next = IW'(1);
            end
          end else begin
            quiet_count_next = quiet_count_reg + QW'(1);
          end
        end
        RELEASING: begin
          if (delay_count_reg == DELAY_LAST) begin
            delay_count_next = '0;
            stage_reset_next = stage_reset_reg & ~release_mask;
            if (stage_index_reg == LAST_INDEX) begin
              state_next        = RUNNING;
              in_progress_next  = 1'b0;
              all_released_next = 1'b1;
            end else begin
              stage_index_next = stage_index_reg + IW'(1);
            end
          end else begin
            delay_count_next = delay_count_reg + DW'(1);
          end
        end
        RUNNING: begin
          state_next = RUNNING;
        end
        default: begin
          state_next       = HOLD;
          stage_reset_next = '1;
          in_progress_next = 1'b0;
          all_released_next = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; local reset overrides everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      prev_sync_reg    <= 1'b1;
      state_reg        <= HOLD;
      quiet_count_reg  <= '0;
      delay_count_reg  <= '0;
      stage_index_reg  <= '0;
      stage_reset_reg  <= '1;
      in_progress_reg  <= 1'b0;
      all_released_reg <= 1'b0;
      event_count_reg  <= '0;
    end else begin
      prev_sync_reg    <= sync_req;
      state_reg        <= state_next;
      quiet_count_reg  <= quiet_count_next;
      delay_count_reg  <= delay_count_next;
      stage_index_reg  <= stage_index_next;
      stage_reset_reg  <= stage_reset_next;
      in_progress_reg  <= in_progress_next;
      all_released_reg <= all_released_next;
      event_count_reg  <= event_count_next;
    end
  end

  assign stage_reset         = stage_reset_reg;
  assign release_in_progress = in_progress_reg;
  assign all_released        = all_released_reg;
  assign reset_event_count   = event_count_reg;

endmodule

// File: tb/tb_reset_receiver.sv
// Scoreboard bench for reset_receiver: expected output snapshots are queued
// against an absolute edge number when stimulus is driven, then compared on
// the falling clock edge that follows that rising edge.
module tb_reset_receiver;

  logic       clock;
  logic       reset;
  logic       req;
  logic [3:0] stage;
  logic       rip;
  logic       all_rel;
  logic [7:0] count;

  logic       reset_sat;
  logic       req_sat;
  logic [3:0] stage_sat;
  logic       rip_sat;
  logic       all_sat;
  logic [1:0] count_sat;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         at;
    bit         sat;
    logic [3:0] stage;
    logic       rip;
    logic       all;
    int         cnt;
  } exp_t;

  exp_t exp_q[$];

  reset_receiver dut (
    .clock                  (clock),
    .reset                  (reset),
    .upstream_reset_request (req),
    .stage_reset            (stage),
    .release_in_progress    (rip),
    .all_released           (all_rel),
    .reset_event_count      (count)
  );

  reset_receiver #(.EVENT_COUNTER_WIDTH(2)) dut_sat (
    .clock                  (clock),
    .reset                  (reset_sat),
    .upstream_reset_request (req_sat),
    .stage_reset            (stage_sat),
    .release_in_progress    (rip_sat),
    .all_released           (all_sat),
    .reset_event_count      (count_sat)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Rising-edge counter: value n at a falling edge means edge n has just happened.
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_value(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic push_exp(input int at, input logic [3:0] st, input logic r, input logic a, input int cnt);
    exp_t e;
    e.at = at; e.sat = 1'b0; e.stage = st; e.rip = r; e.all = a; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  task automatic push_sat(input int at, input int cnt);
    exp_t e;
    e.at = at; e.sat = 1'b1; e.stage = 4'hF; e.rip = 1'b0; e.all = 1'b0; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  // Full release timeline after the request (or reset) is last seen high at edge c0.
  task automatic expect_release(input int c0, input int cnt);
    push_exp(c0 + 9,  4'b1111, 1'b0, 1'b0, cnt);
    push_exp(c0 + 10, 4'b1110, 1'b1, 1'b0, cnt);
    push_exp(c0 + 25, 4'b1110, 1'b1, 1'b0, cnt);
    push_exp(c0 + 26, 4'b1100, 1'b1, 1'b0, cnt);
    push_exp(c0 + 41, 4'b1100, 1'b1, 1'b0, cnt);
    push_exp(c0 + 42, 4'b1000, 1'b1, 1'b0, cnt);
    push_exp(c0 + 57, 4'b1000, 1'b1, 1'b0, cnt);
    push_exp(c0 + 58, 4'b0000, 1'b0, 1'b1, cnt);
    push_exp(c0 + 70, 4'b0000, 1'b0, 1'b1, cnt);
  endtask

  // Scoreboard: compare every entry due at this edge, one line per transaction.
  always @(negedge clock) begin
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].at == cyc) begin
        if (exp_q[i].sat) begin
          $display("tx edge %0d sat: stage=%b count=%0d", cyc, stage_sat, count_sat);
          check_value($sformatf("sat_count e%0d", cyc), 32'(count_sat), 32'(exp_q[i].cnt));
          check_value($sformatf("sat_stage e%0d", cyc), 32'(stage_sat), 32'(exp_q[i].stage));
        end else begin
          $display("tx edge %0d: stage=%b rip=%b all=%b count=%0d", cyc, stage, rip, all_rel, count);
          check_value($sformatf("stage_reset e%0d", cyc), 32'(stage), 32'(exp_q[i].stage));
          check_value($sformatf("release_in_progress e%0d", cyc), 32'(rip), 32'(exp_q[i].rip));
          check_value($sformatf("all_released e%0d", cyc), 32'(all_rel), 32'(exp_q[i].all));
          check_value($sformatf("event_count e%0d", cyc), 32'(count), 32'(exp_q[i].cnt));
        end
        exp_q.delete(i);
      end
    end
  end

  initial begin
    int c;
    int c0;
    reset = 1'b1; req = 1'b0; reset_sat = 1'b1; req_sat = 1'b0;

    // Power-up release after a local reset pulse.
    repeat (3) @(negedge clock);
    push_exp(cyc + 1, 4'b1111, 1'b0, 1'b0, 0);
    @(negedge clock);
    reset = 1'b0;
    expect_release(cyc, 0);
    repeat (72) @(negedge clock);

    // Request while running: assert takes effect at edge 3, then re-release.
    req = 1'b1; c = cyc;
    push_exp(c + 2, 4'b0000, 1'b0, 1'b1, 0);
    push_exp(c + 3, 4'b1111, 1'b0, 1'b0, 1);
    repeat (5) @(negedge clock);
    req = 1'b0;
    expect_release(cyc, 1);
    repeat (72) @(negedge clock);

    // Glitch during the quiet time restarts the full quiet interval.
    req = 1'b1; c = cyc;
    push_exp(c + 3, 4'b1111, 1'b0, 1'b0, 2);
    repeat (4) @(negedge clock);
    req = 1'b0;
    repeat (6) @(negedge clock);
    req = 1'b1;
    push_exp(c + 13, 4'b1111, 1'b0, 1'b0, 3);
    push_exp(c + 14, 4'b1111, 1'b0, 1'b0, 3);
    @(negedge clock);
    req = 1'b0;
    expect_release(cyc, 3);
    repeat (72) @(negedge clock);

    // Re-request in the middle of the release sequence.
    req = 1'b1;
    repeat (3) @(negedge clock);
    req = 1'b0; c0 = cyc;
    push_exp(c0 + 10, 4'b1110, 1'b1, 1'b0, 4);
    push_exp(c0 + 26, 4'b1100, 1'b1, 1'b0, 4);
    repeat (30) @(negedge clock);
    req = 1'b1; c = cyc;
    push_exp(c + 2, 4'b1100, 1'b1, 1'b0, 4);
    push_exp(c + 3, 4'b1111, 1'b0, 1'b0, 5);
    repeat (3) @(negedge clock);
    req = 1'b0;
    expect_release(cyc, 5);
    repeat (72) @(negedge clock);

    // Local reset during release; no event counted when it drops.
    req = 1'b1; c = cyc;
    push_exp(c + 3, 4'b1111, 1'b0, 1'b0, 6);
    repeat (3) @(negedge clock);
    req = 1'b0; c0 = cyc;
    push_exp(c0 + 10, 4'b1110, 1'b1, 1'b0, 6);
    repeat (20) @(negedge clock);
    reset = 1'b1;
    push_exp(cyc + 1, 4'b1111, 1'b0, 1'b0, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    expect_release(cyc, 0);
    repeat (72) @(negedge clock);

    // Request and reset drop together: reset wins, quiet time counts afterwards.
    req = 1'b1; c = cyc;
    push_exp(c + 3, 4'b1111, 1'b0, 1'b0, 1);
    repeat (5) @(negedge clock);
    reset = 1'b1;
    push_exp(cyc + 1, 4'b1111, 1'b0, 1'b0, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0; req = 1'b0;
    expect_release(cyc, 0);
    repeat (72) @(negedge clock);

    // Saturation of a 2-bit event counter over five request pulses.
    reset_sat = 1'b0;
    @(negedge clock);
    for (int p = 1; p <= 5; p++) begin
      req_sat = 1'b1;
      push_sat(cyc + 3, (p < 3) ? p : 3);
      repeat (3) @(negedge clock);
      req_sat = 1'b0;
      repeat (3) @(negedge clock);
    end
    repeat (4) @(negedge clock);

    check_value("pending_expectations", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reset_receiver.md
# reset_receiver

Downstream-side companion to the reset generator. Takes that generator's combined `downstream_reset` as an asynchronous request into the downstream clock domain, synchronizes it, enforces a minimum deasserted-quiet time, and releases a bank of per-subsystem resets one stage at a time with a fixed gap between stages. Sits next to each PLL-derived clock domain and feeds resets to the logic in that domain.

## Interface
- `NUMBER_OF_STAGES`, 4: number of staged reset outputs, minimum 1.
- `SYNCHRONIZER_DEPTH`, 2: flip-flops in the request synchronizer, minimum 2.
- `MINIMUM_QUIET_LOG2`, 3: request must be seen low for 2^N consecutive cycles before the first release.
- `STAGE_DELAY_LOG2`, 4: 2^N cycles between consecutive stage releases.
- `EVENT_COUNTER_WIDTH`, 8: width of `reset_event_count`.

Ports:
- `clock` input 1: downstream clock, the only clock.
- `reset` input 1: synchronous, active-high local reset.
- `upstream_reset_request` input 1: asynchronous request, active-high, from the generator's `downstream_reset`.
- `stage_reset` output NUMBER_OF_STAGES: active-high resets; bit 0 releases first.
- `release_in_progress` output 1: high while stages are being released.
- `all_released` output 1: high once every stage is released.
- `reset_event_count` output EVENT_COUNTER_WIDTH: number of request assertions seen; saturating.

## Operation
- The request passes through a synchronizer of SYNCHRONIZER_DEPTH flip-flops. `sync_req` is the last flip-flop. No other logic samples the raw input.
- All outputs are registered.
- State machine:
  - **HOLD**
    - All `stage_reset`=1, `release_in_progress`=0, `all_released`=0.
    - The quiet counter increments on each cycle where `sync_req`=0 and clears on any cycle where `sync_req`=1.
    - When the counter already holds 2^MINIMUM_QUIET_LOG2−1 and `sync_req`=0: go to RELEASING, set `stage_reset[0]`<=0, set `release_in_progress`<=1, clear the stage-delay counter.
  - **RELEASING**
    - The stage-delay counter counts 2^STAGE_DELAY_LOG2 cycles, then clears the next `stage_reset` bit in ascending order.
    - On the edge that clears the last bit: set `all_released`<=1, set `release_in_progress`<=0, go to RUNNING.
  - **RUNNING**: all stages released; hold.
  - **Any state, `sync_req`=1**: go to HOLD. On that edge, set all `stage_reset`<=1, clear `release_in_progress` and `all_released`, clear both counters.
- NUMBER_OF_STAGES=1: go HOLD→RUNNING directly. `stage_reset[0]` and `all_released` change on the same edge. `release_in_progress` never rises.
- Event counter:
  - Increments on each edge where `sync_req` is 1 and its previous value was 0.
  - Saturates at all-ones; never wraps.
- Local `reset`:
  - Overrides everything.
  - Sets all synchronizer flip-flops to 1 (so reset exit produces no spurious event), the previous-`sync_req` register to 1, and the state to HOLD.
  - Clears counters and `reset_event_count`; sets all `stage_reset`=1, `release_in_progress`=0, `all_released`=0.
- Power-up initial values equal the reset values.

## Timing
Defaults throughout; edge 1 is the first clock edge that samples the new request level.
- **Assertion:** `sync_req` rises after edge SYNCHRONIZER_DEPTH. All `stage_reset` and the event-count increment take effect at edge SYNCHRONIZER_DEPTH+1 (edge 3).
- **Deassertion:**
  - `sync_req` falls after edge 2.
  - The quiet counter counts at edges 3..10.
  - `stage_reset[0]` falls at edge SYNCHRONIZER_DEPTH + 2^MINIMUM_QUIET_LOG2 (edge 10).
  - `stage_reset[k]` falls at edge 10 + 16k.
  - `stage_reset[3]` and `all_released`↑ at edge 58; `release_in_progress` is high for edges 10..57.
- **Glitch during quiet time:** a request that returns high before release restarts the full quiet interval.
- **Re-request while RELEASING:** already-released stages re-assert together at edge 3 of the new request.
- **Deasserting request and `reset` in the same cycle:** `reset` wins; the quiet count starts after `reset` drops and the synchronizer has refilled with 0s.

## Test plan
- **Power-up release:** request held low, `reset` pulsed 1 cycle then low → `stage_reset` goes 1111→1110→1100→1000→0000 at edges 10, 26, 42, 58 after `reset` drops; `all_released`=1 at edge 58; `reset_event_count`=0.
- **Request while RUNNING:** request high for 5 cycles, then low → all `stage_reset`=1 at edge 3; `reset_event_count`=1; `stage_reset[0]` falls 10 edges after the falling request is first sampled.
- **Glitch during quiet time:** request high, low for 6 cycles, high 1 cycle, low → no release until 8 consecutive low `sync_req` cycles after the glitch; `reset_event_count` increments by 2.
- **Re-request mid-release:** request asserted between edges 26 and 42 → `stage_reset` returns to 1111 three edges later; `release_in_progress`=0; the sequence restarts from stage 0.
- **Saturation:** with EVENT_COUNTER_WIDTH=2, 5 request pulses → `reset_event_count`=3.
- **Local reset mid-release:** `reset` high during RELEASING → next edge `stage_reset`=1111, counters 0, `reset_event_count`=0, no event counted on exit.
